// File: rtl/block_sequencer.sv
// Debounced switch word -> Lehmer-decoded colour permutation -> slot-by-slot placement.
// Optional SEQ_LOCK_EN: freeze switch sampling while a placing sequence is running.
module block_sequencer #(
  parameter int NUM_SLOTS     = 3,
  parameter int COLOR_W       = 2,
  parameter int SEL_W         = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SEL_W-1:0]               switches,
  input  logic                           start,
  input  logic                           placed,
  output logic [NUM_SLOTS*COLOR_W-1:0]   block_position,
  output logic                           pos_valid,
  output logic                           busy,
  output logic [$clog2(NUM_SLOTS)-1:0]   target_slot,
  output logic [COLOR_W-1:0]             target_color,
  output logic                           target_valid,
  output logic                           seq_done
);

  localparam int POS_W  = NUM_SLOTS * COLOR_W;
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int i = 2; i <= 4; i++)
      if (i <= n) r = r * i;
    return r;
  endfunction

  localparam int NFACT = fact(NUM_SLOTS);

  typedef enum logic [2:0] {
    IDLE, DECODE, READY, RUN, DONE
  } state_t;

  state_t state, state_n;

  logic [SEL_W-1:0]   prev_sw;
  logic [SEL_W-1:0]   committed;
  logic               have_commit;
  logic [CNT_W-1:0]   cnt;
  logic               stable;
  logic               accept;
  logic               lock_hold;
  logic               accept_ok;

  logic [SEL_W-1:0]   rem;
  logic [SLOT_W-1:0]  digit;
  logic [SLOT_W-1:0]  k;
  logic [NUM_SLOTS-1:0] used;
  logic [POS_W-1:0]   acc;

  logic [SEL_W-1:0]   weight;
  logic [SEL_W-1:0]   sel_idx;
  logic               sub;
  logic               last_k;
  logic [COLOR_W-1:0] pick_c;
  logic [POS_W-1:0]   acc_next;
  logic               last_target;

`ifdef SEQ_LOCK_EN
  assign lock_hold = (state == RUN);
  assign accept_ok = (state != DECODE) && (state != RUN);
`else
  assign lock_hold = 1'b0;
  assign accept_ok = (state != DECODE);
`endif

  assign stable = (cnt == CNT_W'(STABLE_CYCLES));
  assign accept = stable && accept_ok &&
                  (!have_commit || prev_sw != committed);

  // Out-of-range selections fall back to the identity permutation
  assign sel_idx = (int'(prev_sw) >= 1 && int'(prev_sw) <= NFACT)
                   ? prev_sw - SEL_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sw <= '0;
      cnt     <= '0;
    end else begin
      prev_sw <= switches;
      if (lock_hold || switches != prev_sw)
        cnt <= '0;
      else if (!stable)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    int seen;
    logic found;
    weight = SEL_W'(fact(NUM_SLOTS - 1 - int'(k)));
    sub    = (rem >= weight);
    last_k = (k == SLOT_W'(NUM_SLOTS - 1));
    pick_c = '0;
    seen   = 0;
    found  = 1'b0;
    for (int c = 0; c < NUM_SLOTS; c++) begin
      if (!used[c]) begin
        if (!found && seen == int'(digit)) begin
          pick_c = COLOR_W'(c);
          found  = 1'b1;
        end
        seen = seen + 1;
      end
    end
    acc_next = acc | (POS_W'(pick_c + COLOR_W'(1))
               << ((NUM_SLOTS - 1 - int'(k)) * COLOR_W));
  end

  assign last_target = (target_slot == SLOT_W'(NUM_SLOTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = DECODE;
      DECODE:  if (!sub && last_k) state_n = READY;
      READY:   if (accept) state_n = DECODE;
               else if (start) state_n = RUN;
      RUN:     if (accept) state_n = DECODE;
               else if (placed && last_target) state_n = DONE;
      DONE:    if (accept) state_n = DECODE;
               else if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      committed      <= '0;
      have_commit    <= 1'b0;
      rem            <= '0;
      digit          <= '0;
      k              <= '0;
      used           <= '0;
      acc            <= '0;
      block_position <= '0;
    end else if (accept) begin
      committed   <= prev_sw;
      have_commit <= 1'b1;
      rem         <= sel_idx;
      digit       <= '0;
      k           <= '0;
      used        <= '0;
      acc         <= '0;
    end else if (state == DECODE) begin
      if (sub) begin
        rem   <= rem - weight;
        digit <= digit + SLOT_W'(1);
      end else begin
        used  <= used | (NUM_SLOTS'(1) << pick_c);
        acc   <= acc_next;
        digit <= '0;
        k     <= k + SLOT_W'(1);
        if (last_k) block_position <= acc_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      target_slot <= '0;
    else if (state_n == RUN && state != RUN)
      target_slot <= '0;
    else if (state == RUN && state_n == RUN && placed)
      target_slot <= target_slot + SLOT_W'(1);
  end

  assign busy         = (state == DECODE);
  assign pos_valid    = (state == READY) || (state == RUN) || (state == DONE);
  assign target_valid = (state == RUN);
  assign seq_done     = (state == DONE);
  assign target_color = target_valid
    ? block_position[(NUM_SLOTS - 1 - int'(target_slot)) * COLOR_W +: COLOR_W]
    : '0;

endmodule
